// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: 2-flop synchroniser, fixed-width active-low pulse with press strobe, hold-off, re-arm on release.
// Optional auto-repeat while held is enabled by defining BUTTON_CONDITIONER_REPEAT_EN.
module button_conditioner #(
  parameter int CHANNELS     = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int PULSE_LEN    = 16,
  parameter int HOLDOFF      = 8388608,
  parameter int REPEAT_DELAY = 4194304
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] busy
);

  localparam int CNT_TOP = (HOLDOFF > REPEAT_DELAY) ? HOLDOFF : REPEAT_DELAY;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic          IDLE_LVL   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF - 1);
  localparam logic [CW-1:0] CNT_SAT    = '1;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_DELAY - 1);
`endif

  typedef enum logic [1:0] {IDLE, PULSE, HOLD, WAIT_REL} state_t;

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic          sync1;
      logic          sync2;
      logic          pressed;
      state_t        state;
      state_t        state_nxt;
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_nxt;
      logic [CW-1:0] cnt_inc;
      logic          out_ch;
      logic          press_ch;
      logic          busy_ch;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1 <= IDLE_LVL;
          sync2 <= IDLE_LVL;
        end else begin
          sync1 <= in[i];
          sync2 <= sync1;
        end
      end

      assign pressed = (sync2 != IDLE_LVL);

      // Saturating increment: the counter never wraps while a button is held.
      assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= state_nxt;
          cnt   <= cnt_nxt;
        end
      end

      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        case (state)
          IDLE: begin
            cnt_nxt = '0;
            if (pressed) state_nxt = PULSE;
          end
          PULSE: begin
            if (cnt == PULSE_LAST) state_nxt = HOLD;
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              cnt_nxt   = '0;
              state_nxt = pressed ? WAIT_REL : IDLE;
            end
          end
          WAIT_REL: begin
            if (!pressed) begin
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end
`ifdef BUTTON_CONDITIONER_REPEAT_EN
            else if (cnt == REP_LAST) begin
              cnt_nxt   = '0;
              state_nxt = PULSE;
            end
`endif
          end
          default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        endcase
      end

      // PULSE is always entered with cnt cleared, so cnt==0 marks its first cycle.
      always_comb begin
        out_ch   = (state != PULSE);
        press_ch = (state == PULSE) && (cnt == '0);
        busy_ch  = (state != IDLE);
      end

      assign out[i]   = out_ch;
      assign press[i] = press_ch;
      assign busy[i]  = busy_ch;
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed table, corner sequences, and random stimulus against a timing-rule reference model.
module tb_button_conditioner;
  localparam int CH = 2;
  localparam int PL = 4;
  localparam int HO = 16;
  localparam int RD = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] in  = '1;
  logic [CH-1:0] out, press, busy;
  logic          out1, press1, busy1;

  always #5 clk = ~clk;

  button_conditioner #(.CHANNELS(CH), .ACTIVE_LOW(1), .PULSE_LEN(PL), .HOLDOFF(HO), .REPEAT_DELAY(RD)) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .press(press), .busy(busy));

  // Single-cycle pulse instance for the PULSE_LEN=1 boundary.
  button_conditioner #(.CHANNELS(1), .ACTIVE_LOW(1), .PULSE_LEN(1), .HOLDOFF(4), .REPEAT_DELAY(64)) dut1 (
    .clk(clk), .rst(rst), .in(in[0]), .out(out1), .press(press1), .busy(busy1));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: each channel is described by the edge number its pulse started at,
  // plus whether it is past hold-off waiting for release. Outputs follow from elapsed time.
  logic [CH-1:0] d1 = '1, d2 = '1;
  int            start [CH] = '{-1, -1};
  bit            waiting [CH] = '{0, 0};
  int            now = 0;
  logic [CH-1:0] m_out = '1, m_press = '0, m_busy = '0;
  bit            rep_en;

  initial begin
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
  end

  always @(posedge clk) begin
    logic [CH-1:0] p;
    int e;
    now++;
    p = ~d2;
    if (rst) begin
      d1 = '1; d2 = '1;
      for (int c = 0; c < CH; c++) begin start[c] = -1; waiting[c] = 0; end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (start[c] < 0) begin
          if (p[c]) start[c] = now;
        end else if (!waiting[c]) begin
          if (now - start[c] == HO) begin
            if (p[c]) waiting[c] = 1;
            else start[c] = -1;
          end
        end else begin
          if (!p[c]) begin
            waiting[c] = 0; start[c] = -1;
          end else if (rep_en && (now - start[c] == HO + RD)) begin
            waiting[c] = 0; start[c] = now;
          end
        end
      end
      d2 = d1; d1 = in;
    end
    for (int c = 0; c < CH; c++) begin
      if (start[c] >= 0 && !waiting[c]) begin
        e = now - start[c];
        m_busy[c]  = 1'b1;
        m_out[c]   = !(e < PL);
        m_press[c] = (e == 0);
      end else begin
        m_busy[c]  = waiting[c];
        m_out[c]   = 1'b1;
        m_press[c] = 1'b0;
      end
    end
  end

  int n_press0, n_low0, n_press1, n_low1, n_low_u1, n_share_u1;
  int ptime [8];

  task automatic clear_counts();
    n_press0 = 0; n_low0 = 0; n_press1 = 0; n_low1 = 0; n_low_u1 = 0; n_share_u1 = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [CH-1:0] i);
    rst = r;
    in  = i;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("model", {26'b0, out, press, busy}, {26'b0, m_out, m_press, m_busy});
    if (press[0]) begin
      if (n_press0 < 8) ptime[n_press0] = cyc;
      n_press0++;
    end
    n_low0     += int'(!out[0]);
    n_press1   += int'(press[1]);
    n_low1     += int'(!out[1]);
    n_low_u1   += int'(!out1);
    n_share_u1 += int'(press1 && !out1);
  endtask

  typedef struct {
    logic          r;
    logic [CH-1:0] i;
    logic [5:0]    exp;   // {out, press, busy}
  } vec_t;

  vec_t tbl [9];
  int   exp_rep;
  bit   found;

  initial begin
    tbl[0] = '{1'b1, 2'b00, 6'b11_00_00};
    tbl[1] = '{1'b1, 2'b00, 6'b11_00_00};
    tbl[2] = '{1'b0, 2'b00, 6'b11_00_00};
    tbl[3] = '{1'b0, 2'b11, 6'b11_00_00};
    tbl[4] = '{1'b0, 2'b11, 6'b00_11_11};
    tbl[5] = '{1'b0, 2'b11, 6'b00_00_11};
    tbl[6] = '{1'b0, 2'b11, 6'b00_00_11};
    tbl[7] = '{1'b0, 2'b11, 6'b00_00_11};
    tbl[8] = '{1'b0, 2'b11, 6'b11_00_11};

    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      step(tbl[k].r, tbl[k].i);
      check($sformatf("table%0d", k), {26'b0, out, press, busy}, {26'b0, tbl[k].exp});
    end

    // Held press: one pulse of PL cycles, single-cycle pulse on the PULSE_LEN=1 instance.
    step(1, 2'b11); step(1, 2'b11);
    clear_counts();
    for (int k = 0; k < 40; k++) step(0, 2'b10);
    for (int k = 0; k < 30; k++) step(0, 2'b11);
    check("held_press_cnt", n_press0, 1);
    check("held_low_cycles", n_low0, PL);
    check("pl1_low_cycles", n_low_u1, 1);
    check("pl1_press_with_low", n_share_u1, 1);

    // Bounce during pulse and hold-off is ignored.
    clear_counts();
    for (int k = 0; k < 12; k++) step(0, {1'b1, 1'(k % 2)});
    for (int k = 0; k < 30; k++) step(0, 2'b11);
    check("bounce_press_cnt", n_press0, 1);
    check("bounce_low_cycles", n_low0, PL);

    // Simultaneous presses on both channels.
    clear_counts();
    for (int k = 0; k < 6; k++) step(0, 2'b00);
    for (int k = 0; k < 25; k++) step(0, 2'b11);
    check("simul_press0", n_press0, 1);
    check("simul_press1", n_press1, 1);
    check("simul_low1", n_low1, PL);

    // Reset on the second cycle of a pulse aborts it; the next press is full length.
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(0, 2'b10);
      found = press[0];
    end
    check("press_wait", 32'(found), 1);
    step(1, 2'b11);
    check("rst_abort_out0", 32'(out[0]), 1);
    for (int k = 0; k < 5; k++) step(0, 2'b11);
    clear_counts();
    for (int k = 0; k < 6; k++) step(0, 2'b10);
    for (int k = 0; k < 25; k++) step(0, 2'b11);
    check("post_rst_press", n_press0, 1);
    check("post_rst_low", n_low0, PL);

    // Long hold: auto-repeat spacing when enabled, single pulse otherwise.
    clear_counts();
    for (int k = 0; k < 150; k++) step(0, 2'b10);
    for (int k = 0; k < 60; k++) step(0, 2'b11);
    exp_rep = rep_en ? 4 : 1;
    check("long_hold_press_cnt", n_press0, exp_rep);
    if (rep_en && n_press0 >= 4)
      for (int k = 1; k < 4; k++)
        check($sformatf("repeat_gap%0d", k), ptime[k] - ptime[0], k * (HO + RD));

    // Random stimulus: fast-toggling phase, then slow phase that reaches wait-release and repeat.
    begin
      logic [CH-1:0] cur;
      logic          r;
      cur = '1;
      for (int k = 0; k < 3000; k++) begin
        if (k < 1500) cur ^= {1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0)};
        else          cur ^= {1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 39) == 0)};
        r = ($urandom_range(0, 499) == 0);
        step(r, cur);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel successor to the single-button delay/one-shot used for the board push-buttons feeding the processor.
- Per channel:
  - synchronises a raw asynchronous button;
  - emits one fixed-width active-low output pulse and a one-cycle press strobe per press;
  - enforces a programmable hold-off;
  - requires release before re-arming.
- Sits between board buttons and CPU control inputs (step clock, reset request, input-ready).

Parameters:
- CHANNELS, 4, number of independent button channels.
- ACTIVE_LOW, 1, 1 = input pressed when 0; 0 = pressed when 1.
- PULSE_LEN, 16, cycles that out[i] is held low per press; must be >= 1.
- HOLDOFF, 8388608, cycles from pulse start until the channel may leave hold-off; must be > PULSE_LEN.
- REPEAT_DELAY, 4194304, cycles a button must stay held after hold-off before an auto-repeat pulse. Used only with REPEAT_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  CHANNELS  raw asynchronous button levels.
- out  output  CHANNELS  active-low conditioned pulse, one bit per channel.
- press  output  CHANNELS  one-cycle active-high strobe at the start of each pulse.
- busy  output  CHANNELS  high while the channel is not IDLE.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (rst high at a rising edge):
  - out = all 1s; press = 0; busy = 0.
  - every FSM in IDLE; every counter = 0.
  - synchroniser flops = inactive level (1 if ACTIVE_LOW, else 0).
- Reset mid-operation: aborts any pulse; out goes high after that edge.
- Synchroniser: 2 flops per channel. pressed_i = (sync2_i == active level).
- Counter: one per channel, width $clog2(max(HOLDOFF, REPEAT_DELAY)+1). Never wraps; cleared on every state entry listed below.
- Per-channel FSM, channels fully independent:
  - IDLE: out=1, busy=0. If pressed_i: go to PULSE, cnt=0, out=0, press=1 for that cycle only.
  - PULSE: out=0; cnt increments each cycle. When cnt==PULSE_LEN-1: out=1, go to HOLDOFF, cnt keeps incrementing.
  - HOLDOFF: out=1; input ignored. When cnt==HOLDOFF-1:
    - if pressed_i, go to WAIT_RELEASE with cnt=0;
    - else go to IDLE.
  - WAIT_RELEASE: out=1; cnt increments. When !pressed_i, go to IDLE.
- Latency: in sampled active at edge k → out low and press high after edge k+2 (3 edges).
- Pulse length: out low for exactly PULSE_LEN cycles.
- Re-arm: earliest next pulse is HOLDOFF cycles after the previous pulse start.
- Boundary conditions:
  - Bounce or glitch during PULSE or HOLDOFF: ignored.
  - Release during PULSE: pulse still completes its full length.
  - Input held forever: exactly one pulse (without REPEAT_EN).
  - PULSE_LEN=1: press and out-low share a single cycle.
  - Presses on several channels in the same cycle: handled in parallel with no interaction.

Optional Feature:
- Macro: BUTTON_CONDITIONER_REPEAT_EN.
- Defined:
  - In WAIT_RELEASE, when cnt==REPEAT_DELAY-1 and pressed_i is still true: go to PULSE with cnt=0, out=0, press=1.
  - This gives auto-repeat every HOLDOFF+REPEAT_DELAY cycles while the button is held.
  - Release still returns to IDLE immediately.
- Undefined: WAIT_RELEASE only exits on release; REPEAT_DELAY is unused.

Test Plan (CHANNELS=2, ACTIVE_LOW=1, PULSE_LEN=4, HOLDOFF=16, REPEAT_DELAY=32):
- rst high 2 cycles with in=2'b00 → out=2'b11, press=0, busy=0. After rst falls with in still low, out[0] falls 3 edges later.
- in[0] low 1→0 at edge 10, held 40 cycles → press[0]=1 only after edge 12; out[0] low after edges 12–15 (4 cycles); busy until release. No second pulse (macro undefined).
- in[0] bounces 0/1 every cycle for 12 cycles, then stays 1 → exactly one pulse of 4 cycles; busy[0] drops 16 cycles after pulse start.
- in[0] and in[1] fall on the same edge → identical, simultaneous 4-cycle pulses on out[1:0].
- rst asserted on the 2nd cycle of a pulse → out[0]=1 after that edge. Next press produces a full 4-cycle pulse.
- With BUTTON_CONDITIONER_REPEAT_EN, in[0] held 150 cycles → press[0] strobes at pulse start +0, +48, +96, +144.
